// File: rtl/spi_master_ctrl.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, with a start/busy/done
// handshake towards the command logic and a single-frame shift engine.
module spi_master_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              ss_m,
    output logic              sclk_m,
    output logic              mosi_m,
    input  logic              miso_m
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift_tx, shift_tx_nxt;
    logic [DATA_W-1:0] shift_rx, shift_rx_nxt;
    logic [DATA_W-1:0] shift_tx_adv, shift_rx_smp;
    logic [DATA_W-1:0] rx_data_nxt;
    logic              busy_nxt, done_nxt, ss_nxt, sclk_nxt, mosi_nxt;
    logic              phase_end;

    // Next-state and registered-output logic; every phase lasts CLK_DIV cycles.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = (cnt == '0) ? CNT_LOAD : cnt - CNT_W'(1);
        bit_cnt_nxt  = bit_cnt;
        shift_tx_nxt = shift_tx;
        shift_rx_nxt = shift_rx;
        rx_data_nxt  = rx_data;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        ss_nxt       = ss_m;
        sclk_nxt     = sclk_m;
        mosi_nxt     = mosi_m;
        phase_end    = (cnt == '0);
        shift_tx_adv = shift_tx << 1;
        shift_rx_smp = (shift_rx << 1) | DATA_W'(miso_m);

        unique case (state)
            IDLE: begin
                cnt_nxt = CNT_LOAD;
                if (start) begin
                    shift_tx_nxt = tx_data;
                    shift_rx_nxt = '0;
                    bit_cnt_nxt  = '0;
                    busy_nxt     = 1'b1;
                    ss_nxt       = 1'b0;
                    mosi_nxt     = tx_data[DATA_W-1];
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    sclk_nxt     = 1'b1;
                    shift_rx_nxt = shift_rx_smp;
                    bit_cnt_nxt  = BIT_W'(1);
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                // The low half-period after the last falling edge is spent here,
                // so HOLD ends at E0 + CLK_DIV*(2*DATA_W+2).
                if (phase_end) begin
                    if (sclk_m) begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt != BIT_LAST) begin
                            shift_tx_nxt = shift_tx_adv;
                            mosi_nxt     = shift_tx_adv[DATA_W-1];
                        end
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nxt = HOLD;
                    end else begin
                        sclk_nxt     = 1'b1;
                        shift_rx_nxt = shift_rx_smp;
                        bit_cnt_nxt  = bit_cnt + BIT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    ss_nxt      = 1'b1;
                    done_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    mosi_nxt    = 1'b0;
                    rx_data_nxt = shift_rx;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, shift registers and pins; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shift_tx <= '0;
            shift_rx <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ss_m     <= 1'b1;
            sclk_m   <= 1'b0;
            mosi_m   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift_tx <= shift_tx_nxt;
            shift_rx <= shift_rx_nxt;
            rx_data  <= rx_data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            ss_m     <= ss_nxt;
            sclk_m   <= sclk_nxt;
            mosi_m   <= mosi_nxt;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a 16-bit/div-4 instance and an 8-bit/div-1 instance,
// each talking to a behavioural mode-0 slave, checked against a timing model.
module tb_spi_master_ctrl;

    localparam int DW0 = 16, CD0 = 4;
    localparam int DW1 = 8,  CD1 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_v    [2] = '{1'b0, 1'b0};
    logic [15:0] tx_v       [2] = '{16'h0, 16'h0};
    logic [15:0] slave_word [2] = '{16'h0, 16'h0};

    logic        busy0, done0, ss0, sclk0, mosi0;
    logic        busy1, done1, ss1, sclk1, mosi1;
    logic [15:0] rx0;
    logic [7:0]  rx1;
    logic        miso0 = 1'b0, miso1 = 1'b0;

    spi_master_ctrl #(.DATA_W(DW0), .CLK_DIV(CD0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .tx_data(tx_v[0]),
        .busy(busy0), .done(done0), .rx_data(rx0),
        .ss_m(ss0), .sclk_m(sclk0), .mosi_m(mosi0), .miso_m(miso0)
    );

    spi_master_ctrl #(.DATA_W(DW1), .CLK_DIV(CD1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .tx_data(tx_v[1][7:0]),
        .busy(busy1), .done(done1), .rx_data(rx1),
        .ss_m(ss1), .sclk_m(sclk1), .mosi_m(mosi1), .miso_m(miso1)
    );

    function automatic int dw(input int d);
        return (d == 0) ? DW0 : DW1;
    endfunction
    function automatic int cd(input int d);
        return (d == 0) ? CD0 : CD1;
    endfunction
    function automatic int flen(input int d);
        return cd(d) * (2 * dw(d) + 2);
    endfunction
    function automatic logic [15:0] mask(input int d);
        return (d == 0) ? 16'hFFFF : 16'h00FF;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h, expected %0h", name, d, cyc, act, exp);
        end
    endtask

    // Behavioural mode-0 slaves: present MSB when selected, shift on sclk fall.
    logic [15:0] sreg0, sreg1;
    logic        ss0_last = 1'b1, ss1_last = 1'b1;
    always @(ss0 or negedge sclk0) begin
        if (ss0 !== ss0_last) begin
            if (!ss0) sreg0 = slave_word[0];
            ss0_last = ss0;
        end else begin
            sreg0 = sreg0 << 1;
        end
        miso0 = sreg0[15];
    end
    always @(ss1 or negedge sclk1) begin
        if (ss1 !== ss1_last) begin
            if (!ss1) sreg1 = {slave_word[1][7:0], 8'h00};
            ss1_last = ss1;
        end else begin
            sreg1 = sreg1 << 1;
        end
        miso1 = sreg1[15];
    end

    // Reference model: frame acceptance and completion in clock-edge arithmetic.
    typedef struct {
        int          dut;
        int          done_cyc;
        logic [15:0] tx;
        logic [15:0] rx;
    } frame_t;
    frame_t sb_q[$];

    bit          active  [2] = '{1'b0, 1'b0};
    int          e0      [2] = '{0, 0};
    int          fin_cyc [2] = '{-1, -1};
    logic [15:0] ftx     [2] = '{16'h0, 16'h0};
    logic [15:0] frx     [2] = '{16'h0, 16'h0};
    logic [15:0] exp_rx  [2] = '{16'h0, 16'h0};

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                active[d]  = 1'b0;
                exp_rx[d]  = 16'h0;
                fin_cyc[d] = -1;
                for (int i = sb_q.size() - 1; i >= 0; i--)
                    if (sb_q[i].dut == d) sb_q.delete(i);
            end else if (active[d]) begin
                if (cyc == e0[d] + flen(d)) begin
                    active[d]  = 1'b0;
                    exp_rx[d]  = frx[d];
                    fin_cyc[d] = cyc;
                end
            end else if (start_v[d]) begin
                frame_t f;
                active[d] = 1'b1;
                e0[d]     = cyc;
                ftx[d]    = tx_v[d] & mask(d);
                frx[d]    = slave_word[d] & mask(d);
                f.dut      = d;
                f.done_cyc = cyc + flen(d);
                f.tx       = ftx[d];
                f.rx       = frx[d];
                sb_q.push_back(f);
            end
        end
    end

    // Monitor: pin-level checks every cycle, scoreboard pop on each done pulse.
    logic        o_busy [2], o_done [2], o_ss [2], o_sclk [2], o_mosi [2];
    logic [15:0] o_rx   [2];
    logic        ss_prev   [2] = '{1'b1, 1'b1};
    logic        sclk_prev [2] = '{1'b0, 1'b0};
    logic [15:0] col       [2] = '{16'h0, 16'h0};
    int          nrise     [2] = '{0, 0};
    int          last_rise [2] = '{-1, -1};

    always @(negedge clk) begin
        int   rel, idx, hit;
        logic sclk_e, mosi_e;
        o_busy = '{busy0, busy1};
        o_done = '{done0, done1};
        o_ss   = '{ss0, ss1};
        o_sclk = '{sclk0, sclk1};
        o_mosi = '{mosi0, mosi1};
        o_rx   = '{rx0, {8'h00, rx1}};
        for (int d = 0; d < 2; d++) begin
            sclk_e = 1'b0;
            mosi_e = 1'b0;
            if (active[d]) begin
                rel    = cyc - e0[d];
                sclk_e = (rel >= cd(d)) && (rel < 2 * dw(d) * cd(d)) && (((rel / cd(d)) % 2) == 1);
                idx    = rel / (2 * cd(d));
                if (idx > dw(d) - 1) idx = dw(d) - 1;
                mosi_e = ftx[d][dw(d) - 1 - idx];
            end
            chk("busy", d, 32'(o_busy[d]), 32'(active[d]));
            chk("ss_m", d, 32'(o_ss[d]), 32'(!active[d]));
            chk("sclk_m", d, 32'(o_sclk[d]), 32'(sclk_e));
            chk("mosi_m", d, 32'(o_mosi[d]), 32'(mosi_e));
            chk("done", d, 32'(o_done[d]), 32'(fin_cyc[d] == cyc));
            chk("rx_data", d, 32'(o_rx[d]), 32'(exp_rx[d]));

            if (!o_ss[d] && ss_prev[d]) begin
                col[d]       = 16'h0;
                nrise[d]     = 0;
                last_rise[d] = -1;
            end
            if (o_sclk[d] && !sclk_prev[d]) begin
                col[d] = {col[d][14:0], o_mosi[d]};
                nrise[d]++;
                if (last_rise[d] >= 0) chk("sclk_rise_spacing", d, 32'(cyc - last_rise[d]), 32'(2 * cd(d)));
                last_rise[d] = cyc;
            end

            if (o_done[d]) begin
                hit = -1;
                for (int i = 0; i < sb_q.size(); i++)
                    if (hit < 0 && sb_q[i].dut == d) hit = i;
                chk("done_has_frame", d, 32'(hit >= 0), 32'd1);
                if (hit >= 0) begin
                    chk("done_cycle", d, 32'(cyc), 32'(sb_q[hit].done_cyc));
                    chk("frame_rx", d, 32'(o_rx[d]), 32'(sb_q[hit].rx));
                    chk("frame_tx_serial", d, 32'(col[d] & mask(d)), 32'(sb_q[hit].tx));
                    chk("frame_rise_count", d, 32'(nrise[d]), 32'(dw(d)));
                    chk("busy_at_done", d, 32'(o_busy[d]), 32'd0);
                    sb_q.delete(hit);
                end
            end
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].dut == d && sb_q[i].done_cyc < cyc) begin
                    chk("done_missing", d, 32'd0, 32'd1);
                    sb_q.delete(i);
                end
            end
            ss_prev[d]   = o_ss[d];
            sclk_prev[d] = o_sclk[d];
        end
    end

    task automatic pulse_start(input int d, input logic [15:0] tx, input logic [15:0] sw);
        tx_v[d]       = tx;
        slave_word[d] = sw;
        start_v[d]    = 1'b1;
        @(negedge clk);
        start_v[d]    = 1'b0;
    endtask

    initial begin
        // Reset and idle stability.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        // Single frame with a lockout attempt at E0+20.
        pulse_start(0, 16'h7777, 16'hA5C3);
        repeat (19) @(negedge clk);
        pulse_start(0, 16'hFFFF, 16'h0F0F);
        repeat (130) @(negedge clk);

        // Small-parameter corner instance.
        pulse_start(1, 16'h0081, 16'h003C);
        repeat (25) @(negedge clk);

        // Back-to-back frames with start held through the done cycle.
        tx_v[0]       = 16'h1234;
        slave_word[0] = 16'($urandom);
        start_v[0]    = 1'b1;
        @(negedge clk);
        tx_v[0]       = 16'hBEEF;
        slave_word[0] = 16'($urandom);
        repeat (137) @(negedge clk);
        start_v[0]    = 1'b0;
        repeat (140) @(negedge clk);

        // Reset at E0+60, then a clean frame.
        pulse_start(0, 16'($urandom), 16'($urandom));
        repeat (59) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        pulse_start(0, 16'($urandom), 16'($urandom));
        repeat (140) @(negedge clk);

        // Randomised traffic on both instances, including requests while busy.
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                start_v[d]    = ($urandom_range(0, 15) == 0);
                tx_v[d]       = 16'($urandom);
                slave_word[d] = 16'($urandom);
            end
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (150) @(negedge clk);

        chk("scoreboard_drained", 0, 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
